fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Drain-side consumer for the team's 8-deep synchronous byte FIFO: pops bytes through the FIFO read port and transmits each as an 8N1 UART frame on a single serial line. It handles the FIFO's one-cycle registered read latency. It sits between the FIFO read port (`rsig`/`empty`/`rdata`) and the chip-level TX pin. Bytes are sent in FIFO order with no loss or duplication.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range 2..65535.
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: transmit enable, sampled only in IDLE.
- `fifo_empty` in 1: FIFO `empty` flag.
- `fifo_rdata` in 8: FIFO `rdata`; valid the cycle after `fifo_rsig` was high.
- `fifo_rsig` out 1: FIFO read strobe; exactly one cycle per byte.
- `txd` out 1: serial output; idles high.
- `busy` out 1: high whenever state ≠ IDLE.
- `tx_done` out 1: one-cycle pulse on the last cycle of each stop bit.

## Operation
- Reset (`rst`=0, asynchronous): state=IDLE, `txd`=1, `fifo_rsig`=0, `busy`=0, `tx_done`=0, baud counter=0, bit index=0, shift register=0.
- `fifo_rsig` is combinational: `fifo_rsig` = (state==IDLE) && `en` && !`fifo_empty`. All other outputs are registered.
- FSM states and transitions:
  - IDLE: if `fifo_rsig`, go to FETCH next cycle; otherwise stay.
  - FETCH: wait one cycle for FIFO data; go to LOAD.
  - LOAD: capture `fifo_rdata` into the shift register; go to START.
  - START: `txd`=0 for CLKS_PER_BIT cycles; go to DATA.
  - DATA: send 8 bits LSB first, each for CLKS_PER_BIT cycles; bit index 0..7; go to STOP after bit 7.
  - STOP: `txd`=1 for CLKS_PER_BIT cycles; `tx_done`=1 on the final cycle; go to IDLE.
- Baud counter: width ceil(log2(CLKS_PER_BIT)). Counts 0..CLKS_PER_BIT-1 and clears on every bit boundary and on every state entry. Bit index is 3 bits and does not wrap beyond 7.
- `txd` is 1 in IDLE, FETCH, LOAD and STOP.
- `en` deasserted mid-frame: the current frame completes; no new pop follows.
- `fifo_empty` is ignored outside IDLE. A write into an empty FIFO during a frame is picked up at the next IDLE.
- Reset mid-frame: `txd` returns high immediately. The in-flight byte is discarded and is not re-popped.
- A pop is never issued while `fifo_empty`=1, so the FIFO pointers never underflow.

## Timing
- Cycle N: IDLE, `en`=1, `fifo_empty`=0, so `fifo_rsig`=1.
- N+1: FETCH.
- N+2: LOAD; `fifo_rdata` is captured at the end of this cycle.
- First start-bit cycle: `txd` falls at N+3.
- Frame length: 10×CLKS_PER_BIT cycles from start-bit entry to the end of the stop bit.
- Back-to-back operation (FIFO non-empty): the next `fifo_rsig` is asserted in the first IDLE cycle after STOP. This gives a 3-cycle idle-high gap (IDLE, FETCH, LOAD) between frames.
- Total per byte: 10×CLKS_PER_BIT+3 cycles.
- `busy` rises the cycle after `fifo_rsig` and falls the cycle after `tx_done`.

## Test plan
- Single byte, CLKS_PER_BIT=4: FIFO holds 0xA5.
  - Required: one `fifo_rsig` pulse; `txd` falls 3 cycles later.
  - Bit sequence 0,1,0,1,0,0,1,0,1,1, each held for 4 cycles.
  - `tx_done` pulses at cycle 42 relative to the pop; `busy` is low afterwards.
- Back-to-back: push 0x00 then 0xFF.
  - Required: two frames in order, a 3-cycle high gap between them, and exactly two `fifo_rsig` pulses.
- Full FIFO: push 8 bytes 0x01..0x08.
  - Required: 8 frames decoded in order, 8 pops, FIFO empty at the end, no pop while empty.
- Empty or disabled:
  - `fifo_empty`=1 for 100 cycles: `fifo_rsig`, `busy` and `tx_done` stay 0 and `txd` stays 1.
  - Then `en`=0 with data present: no pop occurs.
- `en` dropped mid-DATA while a byte is in flight (0x3C):
  - Required: the frame completes correctly and no further pop follows.
- Reset mid-DATA while sending 0x5A:
  - Required: `txd` is 1 asynchronously and `busy`=0.
  - After release, the next queued byte transmits cleanly; 0x5A is not resent.

Source files
------------

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: read port of the byte FIFO as seen by its drain-side consumer
interface fifo_uart_tx_if;
    logic       fifo_rsig;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;
    modport master (output fifo_rsig, input fifo_empty, fifo_rdata);
    modport slave (input fifo_rsig, output fifo_empty, fifo_rdata);
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a registered-read byte FIFO and sends each byte as an 8N1 UART frame
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    fifo_uart_tx_if.master fifo,
    output logic           txd,
    output logic           busy,
    output logic           tx_done
);
    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
    localparam logic [W-1:0] PRE_LAST = W'(CLKS_PER_BIT - 2);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;
    state_t       state, state_n;
    logic [W-1:0] cnt, cnt_n;
    logic [2:0]   idx, idx_n;
    logic [7:0]   sh, sh_n;
    logic         wrap, timed, txd_n, tx_done_n;
    // gated by reset so a FIFO sharing our reset never sees a pop while it is held
    assign fifo.fifo_rsig = rst && state == IDLE && en && !fifo.fifo_empty;
    assign wrap = cnt == LAST;
    assign timed = state inside {START, DATA, STOP};
    always_comb begin
        state_n = state;
        idx_n = idx;
        sh_n = sh;
        cnt_n = timed && !wrap ? cnt + 1'b1 : '0;
        case (state)
            IDLE:  state_n = fifo.fifo_rsig ? FETCH : IDLE;
            FETCH: state_n = LOAD;
            LOAD: begin
                state_n = START;
                sh_n = fifo.fifo_rdata;
            end
            START: state_n = wrap ? DATA : START;
            DATA: if (wrap) begin
                state_n = idx == 3'd7 ? STOP : DATA;
                idx_n = idx == 3'd7 ? 3'd0 : idx + 3'd1;
                sh_n = sh >> 1;
            end
            STOP:    state_n = wrap ? IDLE : STOP;
            default: state_n = IDLE;
        endcase
        // outputs are registered, so they are derived from the state being entered
        txd_n = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : 1'b1;
        tx_done_n = state == STOP && cnt == PRE_LAST;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            sh <= '0;
            txd <= 1'b1;
            busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            idx <= idx_n;
            sh <= sh_n;
            txd <= txd_n;
            busy <= state_n != IDLE;
            tx_done <= tx_done_n;
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: feeds the UART drain from a behavioural FIFO and decodes the serial line
module tb_fifo_uart_tx;
    localparam int CPB = 4;
    localparam int LASTC = 10 * CPB + 2;
    logic clk = 1'b0, rst = 1'b0, en = 1'b0, wr_en = 1'b0;
    logic txd, busy, tx_done;
    logic [7:0] wr_data = '0;
    logic [7:0] mem[8];
    logic [7:0] exp_q[$];
    int checks = 0, fails = 0;
    int wp = 0, rp = 0, fcnt = 0, pops = 0, underflows = 0;

    fifo_uart_tx_if fif ();
    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .en(en), .fifo(fif),
        .txd(txd), .busy(busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    // 8-deep FIFO with registered read data and a registered empty flag
    assign fif.fifo_empty = fcnt == 0;
    always @(posedge clk) begin
        if (fif.fifo_rsig === 1'b1) begin
            pops <= pops + 1;
            if (fcnt == 0) underflows <= underflows + 1;
            else begin
                fif.fifo_rdata <= mem[rp];
                rp <= (rp + 1) % 8;
            end
        end
        if (wr_en && fcnt < 8) begin
            mem[wp] <= wr_data;
            wp <= (wp + 1) % 8;
        end
        fcnt <= fcnt + ((wr_en && fcnt < 8) ? 1 : 0) - ((fif.fifo_rsig === 1'b1 && fcnt > 0) ? 1 : 0);
    end

    task automatic push(input logic [7:0] d);
        wr_en = 1'b1;
        wr_data = d;
        exp_q.push_back(d);
        @(negedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_pop(input int budget, output int w);
        w = -1;
        #1;
        for (int i = 0; i <= budget; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            if (fif.fifo_rsig === 1'b1) begin
                w = i;
                break;
            end
        end
    endtask

    // Samples one frame starting from the pop cycle; returns raw observations only
    task automatic rx_frame(output logic [9:0] bits, output int glitch, output int done_at,
                            output logic busy_after, output logic next_pop);
        bits = '0;
        glitch = 0;
        done_at = 0;
        busy_after = 1'bx;
        next_pop = 1'bx;
        for (int c = 1; c <= LASTC + 1; c++) begin
            @(negedge clk); #1;
            if (c <= LASTC) begin
                if (fif.fifo_rsig !== 1'b0 || busy !== 1'b1) glitch++;
                if (tx_done === 1'b1 && done_at == 0) done_at = c;
                if (c < 3) begin
                    if (txd !== 1'b1) glitch++;
                end else if ((c - 3) % CPB == 0) bits[(c - 3) / CPB] = txd;
                else if (txd !== bits[(c - 3) / CPB]) glitch++;
            end else begin
                busy_after = busy;
                next_pop = fif.fifo_rsig;
                if (tx_done !== 1'b0 || txd !== 1'b1) glitch++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({txd, busy, tx_done, fif.fifo_rsig} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_outputs: txd/busy/done/rsig got %b want 1000", {txd, busy, tx_done, fif.fifo_rsig});
        end
        rst = 1'b1;
        en = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({txd, busy, tx_done, fif.fifo_rsig} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_release: txd/busy/done/rsig got %b want 1000", {txd, busy, tx_done, fif.fifo_rsig});
        end
    endtask

    task automatic test_single();
        logic [9:0] bits;
        logic [7:0] e;
        logic ba, np;
        int g, d, w, p0;
        en = 1'b0;
        push(8'hA5);
        p0 = pops;
        en = 1'b1;
        wait_pop(20, w);
        checks++;
        if (w !== 0) begin fails++; $display("FAIL single_pop: waited %0d want 0", w); end
        rx_frame(bits, g, d, ba, np);
        e = exp_q.pop_front();
        checks++;
        if (bits !== {1'b1, e, 1'b0}) begin fails++; $display("FAIL single_bits: got %b want %b", bits, {1'b1, e, 1'b0}); end
        checks++;
        if (g !== 0 || d !== LASTC || ba !== 1'b0 || np !== 1'b0) begin
            fails++;
            $display("FAIL single_timing: glitches %0d done_at %0d busy_after %b next_pop %b, want 0 %0d 0 0", g, d, ba, np, LASTC);
        end
        checks++;
        if (pops - p0 !== 1) begin fails++; $display("FAIL single_pops: got %0d want 1", pops - p0); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] bits;
        logic [7:0] e;
        logic ba, np;
        int g, d, w, p0;
        en = 1'b0;
        push(8'h00);
        push(8'hFF);
        p0 = pops;
        en = 1'b1;
        wait_pop(20, w);
        checks++;
        if (w < 0) begin fails++; $display("FAIL b2b_pop: no pop within budget, got %0d want >=0", w); end
        for (int k = 0; k < 2; k++) begin
            rx_frame(bits, g, d, ba, np);
            e = exp_q.pop_front();
            checks++;
            if (bits !== {1'b1, e, 1'b0}) begin fails++; $display("FAIL b2b_bits %0d: got %b want %b", k, bits, {1'b1, e, 1'b0}); end
            checks++;
            if (g !== 0 || d !== LASTC || ba !== 1'b0 || np !== 1'(k == 0)) begin
                fails++;
                $display("FAIL b2b_timing %0d: glitches %0d done_at %0d busy_after %b next_pop %b, want 0 %0d 0 %b", k, g, d, ba, np, LASTC, k == 0);
            end
        end
        checks++;
        if (pops - p0 !== 2) begin fails++; $display("FAIL b2b_pops: got %0d want 2", pops - p0); end
    endtask

    task automatic test_full();
        logic [9:0] bits;
        logic [7:0] e;
        logic ba, np;
        int g, d, w, p0, u0;
        en = 1'b0;
        for (int v = 1; v <= 8; v++) push(8'(v));
        p0 = pops;
        u0 = underflows;
        en = 1'b1;
        wait_pop(20, w);
        for (int k = 0; k < 8; k++) begin
            rx_frame(bits, g, d, ba, np);
            e = exp_q.pop_front();
            checks++;
            if (bits !== {1'b1, e, 1'b0} || g !== 0 || d !== LASTC || np !== 1'(k < 7)) begin
                fails++;
                $display("FAIL full_frame %0d: bits %b glitches %0d done_at %0d next_pop %b, want %b 0 %0d %b", k, bits, g, d, np, {1'b1, e, 1'b0}, LASTC, k < 7);
            end
        end
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (pops - p0 !== 8 || underflows !== u0 || fif.fifo_empty !== 1'b1) begin
            fails++;
            $display("FAIL full_drain: pops %0d underflows %0d empty %b, want 8 %0d 1", pops - p0, underflows, fif.fifo_empty, u0);
        end
    endtask

    task automatic test_empty_disabled();
        logic [9:0] bits;
        logic [7:0] e;
        logic ba, np;
        int g, d, w, bad, p0;
        en = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (fif.fifo_rsig !== 1'b0 || busy !== 1'b0 || tx_done !== 1'b0 || txd !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin fails++; $display("FAIL empty_idle: %0d active cycles, want 0", bad); end
        en = 1'b0;
        push(8'h42);
        p0 = pops;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (fif.fifo_rsig !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0 || pops !== p0) begin fails++; $display("FAIL disabled_pop: active %0d pops %0d, want 0 0", bad, pops - p0); end
        en = 1'b1;
        wait_pop(20, w);
        rx_frame(bits, g, d, ba, np);
        e = exp_q.pop_front();
        checks++;
        if (bits !== {1'b1, e, 1'b0} || g !== 0 || d !== LASTC || w < 0) begin
            fails++;
            $display("FAIL enable_frame: bits %b glitches %0d done_at %0d waited %0d, want %b 0 %0d >=0", bits, g, d, w, {1'b1, e, 1'b0}, LASTC);
        end
    endtask

    task automatic test_en_drop();
        logic [9:0] bits;
        logic [7:0] e;
        logic ba, np;
        int g, d, w, bad, p0;
        en = 1'b0;
        push(8'h3C);
        push(8'h99);
        p0 = pops;
        en = 1'b1;
        wait_pop(20, w);
        fork
            rx_frame(bits, g, d, ba, np);
            begin repeat (20) @(negedge clk); en = 1'b0; end
        join
        e = exp_q.pop_front();
        checks++;
        if (bits !== {1'b1, e, 1'b0} || g !== 0 || d !== LASTC || np !== 1'b0) begin
            fails++;
            $display("FAIL en_drop_frame: bits %b glitches %0d done_at %0d next_pop %b, want %b 0 %0d 0", bits, g, d, np, {1'b1, e, 1'b0}, LASTC);
        end
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (fif.fifo_rsig !== 1'b0 || txd !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0 || pops - p0 !== 1) begin fails++; $display("FAIL en_drop_nopop: active %0d pops %0d, want 0 1", bad, pops - p0); end
        en = 1'b1;
        wait_pop(20, w);
        rx_frame(bits, g, d, ba, np);
        e = exp_q.pop_front();
        checks++;
        if (bits !== {1'b1, e, 1'b0} || g !== 0 || d !== LASTC) begin
            fails++;
            $display("FAIL en_resume_frame: bits %b glitches %0d done_at %0d, want %b 0 %0d", bits, g, d, {1'b1, e, 1'b0}, LASTC);
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] bits;
        logic [7:0] e, nxt;
        logic ba, np;
        int g, d, w, bad, p0;
        nxt = 8'($urandom_range(0, 255));
        en = 1'b0;
        push(8'h5A);
        push(nxt);
        p0 = pops;
        en = 1'b1;
        wait_pop(20, w);
        repeat (3 + 3 * CPB) begin @(negedge clk); #1; end
        checks++;
        if (txd !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL rst_mid_pre: txd %b busy %b, want 0 1", txd, busy); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({txd, busy, fif.fifo_rsig} !== 3'b100) begin
            fails++;
            $display("FAIL rst_mid_async: txd/busy/rsig got %b want 100", {txd, busy, fif.fifo_rsig});
        end
        @(negedge clk); #1;
        checks++;
        if ({txd, busy, tx_done, fif.fifo_rsig} !== 4'b1000) begin
            fails++;
            $display("FAIL rst_mid_hold: txd/busy/done/rsig got %b want 1000", {txd, busy, tx_done, fif.fifo_rsig});
        end
        rst = 1'b1;
        void'(exp_q.pop_front());
        wait_pop(20, w);
        rx_frame(bits, g, d, ba, np);
        e = exp_q.pop_front();
        checks++;
        if (bits !== {1'b1, e, 1'b0} || g !== 0 || d !== LASTC || np !== 1'b0) begin
            fails++;
            $display("FAIL rst_next_frame: bits %b glitches %0d done_at %0d next_pop %b, want %b 0 %0d 0", bits, g, d, np, {1'b1, e, 1'b0}, LASTC);
        end
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (fif.fifo_rsig !== 1'b0 || txd !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0 || pops - p0 !== 2) begin fails++; $display("FAIL rst_no_resend: active %0d pops %0d, want 0 2", bad, pops - p0); end
    endtask

    task automatic test_random();
        logic [9:0] bits;
        logic [7:0] e;
        logic ba, np;
        int g, d, w, n, p0;
        n = int'($urandom_range(3, 8));
        en = 1'b0;
        for (int k = 0; k < n; k++) push(8'($urandom_range(0, 255)));
        p0 = pops;
        en = 1'b1;
        wait_pop(20, w);
        for (int k = 0; k < n; k++) begin
            rx_frame(bits, g, d, ba, np);
            e = exp_q.pop_front();
            checks++;
            if (bits !== {1'b1, e, 1'b0} || g !== 0 || d !== LASTC || np !== 1'(k < n - 1)) begin
                fails++;
                $display("FAIL random_frame %0d: bits %b glitches %0d done_at %0d next_pop %b, want %b 0 %0d %b", k, bits, g, d, np, {1'b1, e, 1'b0}, LASTC, k < n - 1);
            end
        end
        checks++;
        if (pops - p0 !== n || exp_q.size() !== 0) begin
            fails++;
            $display("FAIL random_pops: pops %0d left %0d, want %0d 0", pops - p0, exp_q.size(), n);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_empty_disabled();
        test_en_drop();
        test_reset_mid();
        test_random();
        checks++;
        if (underflows !== 0) begin fails++; $display("FAIL underflow: got %0d want 0", underflows); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
